// File: rtl/bus_terminal_rx.sv
// Receive-side terminal agent: filters bus pushes by destination address and buffers
// accepted words in a show-ahead FIFO for a local consumer. It also keeps drop and error statistics.
module bus_terminal_rx #(
    parameter int         ancho_pal   = 32,
    parameter logic [7:0] terminal_id = 8'd0,
    parameter logic [7:0] broadcast   = 8'hFF,
    parameter int         profundidad = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ancho_pal-1:0]           D_push,
    input  logic                           rd_en,
    output logic [ancho_pal-1:0]           rd_data,
    output logic                           rd_valid,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(profundidad):0]   count,
    output logic [15:0]                    ovf_cnt,
    output logic                           err_addr,
    output logic [15:0]                    bcast_cnt
);

    localparam int            AW    = $clog2(profundidad);
    localparam int            CW    = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(profundidad);

    logic [ancho_pal-1:0] mem_q [profundidad];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   ovfCnt_q, ovfCnt_d;
    logic [15:0]   bcastCnt_q, bcastCnt_d;
    logic          errAddr_q, errAddr_d;

    logic [7:0] dest;
    logic       addrHit;
    logic       isBcast;
    logic       isEmpty;
    logic       isFull;
    logic       rdEff;
    logic       wrEn;
    logic       ovfEv;
    logic       missEv;

    always_comb begin
        dest    = D_push[ancho_pal-1 -: 8];
        isBcast = (dest == broadcast);
        addrHit = (dest == terminal_id) || isBcast;
        isEmpty = (count_q == '0);
        isFull  = (count_q == DEPTH);
        rdEff   = rd_en & ~isEmpty;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        wrEn    = push & addrHit & (~isFull | rdEff);
        ovfEv   = push & addrHit & isFull & ~rdEff;
        missEv  = push & ~addrHit;
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        ovfCnt_d   = ovfCnt_q;
        bcastCnt_d = bcastCnt_q;
        errAddr_d  = errAddr_q;

        if (wrEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (isBcast && (bcastCnt_q != 16'hFFFF)) begin
                bcastCnt_d = bcastCnt_q + 16'd1;
            end
        end

        if (rdEff) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case ({wrEn, rdEff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (ovfEv && (ovfCnt_q != 16'hFFFF)) begin
            ovfCnt_d = ovfCnt_q + 16'd1;
        end

        if (missEv) begin
            errAddr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ovfCnt_q   <= '0;
            bcastCnt_q <= '0;
            errAddr_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            ovfCnt_q   <= ovfCnt_d;
            bcastCnt_q <= bcastCnt_d;
            errAddr_q  <= errAddr_d;
        end
    end

    // Storage needs no reset; the pointers and count alone define which words are live.
    always_ff @(posedge clk) begin
        if (!reset && wrEn) begin
            mem_q[wrPtr_q] <= D_push;
        end
    end

    always_comb begin
        rd_data   = isEmpty ? '0 : mem_q[rdPtr_q];
        rd_valid  = ~isEmpty;
        full      = isFull;
        empty     = isEmpty;
        count     = count_q;
        ovf_cnt   = ovfCnt_q;
        err_addr  = errAddr_q;
        bcast_cnt = bcastCnt_q;
    end

endmodule

// File: doc/bus_terminal_rx.md
Name: bus_terminal_rx

Overview:
Receive-side terminal agent for the bs_gnrtr_n_rbtr bus. It is the opposite end from the input FIFO, which presents pndng/D_pop and is popped by the bus; this block instead accepts push/D_push words delivered by the bus to one terminal. It checks each word's destination field, buffers accepted words in a show-ahead FIFO, and exposes them to a local consumer through a read handshake. It also keeps error and overflow statistics. One instance sits on each terminal's push/D_push lane.

Parameters:
ancho_pal, 32, packet width in bits; destination address occupies bits [ancho_pal-1 -: 8]
terminal_id, 0, 8-bit address of this terminal
broadcast, 8'hFF, destination value accepted by every terminal
profundidad, 8, FIFO depth in words; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
push  input  1  bus strobe; D_push is valid this cycle
D_push  input  ancho_pal  packet from bus
rd_en  input  1  consumer pop request
rd_data  output  ancho_pal  head-of-FIFO word; 0 when empty
rd_valid  output  1  head word valid (equals !empty)
full  output  1  FIFO holds profundidad words
empty  output  1  FIFO holds 0 words
count  output  $clog2(profundidad)+1  words currently stored
ovf_cnt  output  16  accepted-address pushes dropped because the FIFO was full
err_addr  output  1  sticky flag; a push carried a foreign destination
bcast_cnt  output  16  broadcast words stored

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, ovf_cnt=0, bcast_cnt=0, err_addr=0. Memory contents are don't-care.
- Reset asserted mid-stream discards all stored words. A push in the reset cycle is ignored.
- Address decode, with dest = D_push[ancho_pal-1 -: 8]:
  - Hit when dest==terminal_id or dest==broadcast.
  - A miss on push sets err_addr, which stays set until reset. The word is not stored and the counters do not change.
- Write: on push & hit & (!full | rd_eff), store D_push unmodified at wr_ptr. wr_ptr increments modulo profundidad (wrap-around).
  - If dest==broadcast, bcast_cnt increments, saturating at 16'hFFFF.
- Overflow: on push & hit & full & !rd_eff, drop the word. ovf_cnt increments, saturating at 16'hFFFF. The bus has no backpressure, so the drop is silent apart from the counter.
- Read: rd_eff = rd_en & !empty. On rd_eff, rd_ptr increments modulo profundidad.
  - rd_en while empty is ignored: no pointer change, no error.
- Show-ahead output:
  - rd_data = mem[rd_ptr] when !empty, else 0.
  - A word written at edge N appears on rd_data/rd_valid in the cycle after edge N, i.e. 1-cycle latency into an empty FIFO.
- count update: +1 on write only, -1 on rd_eff only, unchanged on both or neither.
  - full = (count==profundidad); empty = (count==0).
- Simultaneous events:
  - Full + accepted push + rd_en: pop and write both occur; count stays profundidad; no overflow.
  - Empty + push + rd_en: write occurs; rd_en is ignored; count becomes 1.
- No other state machine: the FIFO control is the counter/pointer state, and the counters saturate.

Test Plan:
1. Parameters terminal_id=2, profundidad=4. After reset, push D_push=32'h02_00_00_AA. -> Next cycle: rd_valid=1, rd_data=32'h020000AA, count=1. Pulse rd_en -> empty=1, rd_data=0.
2. Push 32'hFF000001 (broadcast) -> stored, bcast_cnt=1. Push 32'h01000005 -> not stored, err_addr=1, count unchanged; err_addr stays 1 through later traffic until reset.
3. Push 4 hits (32'h02000001..4), giving full=1. Push a 5th hit 32'h02000005 with rd_en=0 -> dropped, ovf_cnt=1. Read all -> 01,02,03,04 in order.
4. With full=1, push 32'h02000009 while rd_en=1 -> count stays 4, ovf_cnt unchanged. Reading out gives 02,03,04,09, which checks pointer wrap.
5. Empty FIFO, push 32'h02000077 with rd_en=1 in the same cycle -> count=1, rd_data=32'h02000077 next cycle.
6. Load 3 words, assert reset for 1 cycle together with a push -> count=0, empty=1, ovf_cnt=0, bcast_cnt=0, err_addr=0; the pushed word is absent.
